vai_rd_credit_sched: RTL and testbench
======================================

Name: vai_rd_credit_sched

Overview:
- Per-sub-AFU read-credit scheduler for the VAI multiplexer Tx path.
- Sits between the per-AFU audited Tx request streams and the shared upstream Tx channel.
- Each cycle it grants at most one requester, chosen round-robin among eligible requesters.
- Caps outstanding upstream reads per sub-AFU, so no single tenant can monopolise read tags or bandwidth; the manager AFU programs limits and can flush a tenant on sub-AFU reset.

Parameters:
- NUM_SUB_AFUS, 15, number of requesters (index NUM_SUB_AFUS-1 is normally the manager AFU).
- CNT_W, 8, width of per-requester outstanding-read counter and limit.
- DEFAULT_LIMIT, 32, per-requester read limit loaded at reset.
- IDX_W, $clog2(NUM_SUB_AFUS), requester index width.

Ports:
- clk  in  1  pClk domain clock.
- reset  in  1  synchronous active-high reset.
- req_valid  in  NUM_SUB_AFUS  requester i has a Tx request pending.
- req_is_rd  in  NUM_SUB_AFUS  pending request of i is a read (consumes credit).
- up_almfull  in  1  upstream Tx almost-full; blocks all grants.
- grant  out  NUM_SUB_AFUS  one-hot grant, combinational.
- grant_valid  out  1  OR of grant.
- grant_idx  out  IDX_W  encoded index of grant; 0 when grant_valid=0.
- rsp_valid  in  1  a read response returned upstream.
- rsp_idx  in  IDX_W  requester owning that response.
- sub_afu_reset  in  NUM_SUB_AFUS  per-tenant flush from manager.
- cfg_wr  in  1  limit write strobe.
- cfg_idx  in  IDX_W  limit write target.
- cfg_limit  in  CNT_W  new limit value.
- busy  out  NUM_SUB_AFUS  registered; outstanding[i]!=0.
- err_underflow  out  1  sticky; response arrived for a requester with zero outstanding.

Behaviour:
- State: ptr[IDX_W], outstanding[i][CNT_W], limit[i][CNT_W], err_underflow.
- Reset values: ptr=0, outstanding=0, limit=DEFAULT_LIMIT, err_underflow=0, busy=0. Grant outputs are 0 while reset=1.
- Eligibility: elig[i] = req_valid[i] & ~sub_afu_reset[i] & (~req_is_rd[i] | outstanding[i] < limit[i]).
  - limit=0 blocks reads only; writes remain eligible.
- Arbitration (same cycle as request, zero latency):
  - If up_almfull=1, there is no grant.
  - Otherwise grant the first elig[i] scanning ptr, ptr+1, ..., wrapping modulo NUM_SUB_AFUS.
- Pointer update: on grant_valid, ptr <= (grant_idx+1) mod NUM_SUB_AFUS. The wrap from NUM_SUB_AFUS-1 goes to 0, including non-power-of-2 N. ptr holds when there is no grant.
- Handshake: a requester keeps req_valid until granted; the grant is the consume.
- Counter update per i, per cycle:
  - inc = grant[i] & req_is_rd[i].
  - dec = rsp_valid & rsp_idx==i.
  - inc & dec: unchanged.
  - inc only: +1. Cannot overflow, since inc requires outstanding<limit≤2^CNT_W-1.
  - dec only with outstanding[i]=0: remains 0 and err_underflow <= 1.
  - dec only otherwise: -1.
- sub_afu_reset[i]=1: outstanding[i] <= 0 (priority over inc/dec), no grant to i. A dec for i during flush does not set err_underflow. Late responses after flush to a zero counter do set err_underflow (visible to manager).
- cfg_wr: limit[cfg_idx] <= cfg_limit next cycle.
  - Lowering below the current outstanding count makes i ineligible for reads until it drains below the new limit. Counter untouched.
  - cfg_idx ≥ NUM_SUB_AFUS is ignored.
- rsp_idx ≥ NUM_SUB_AFUS: ignored, err_underflow <= 1.
- busy[i] registered from next-state outstanding (reflects the counter one cycle after update).
- Reset mid-operation: all counters clear and ptr=0 the next cycle regardless of in-flight requests. Subsequent responses set err_underflow.

Test Plan:
- N=4, all req_valid=1 and writes, 8 cycles → grant_idx 0,1,2,3,0,1,2,3; ptr wraps.
- N=15, only requesters 14 and 0 valid, ptr=14 → grants 14, 0, 14, 0, covering the non-power-of-2 wrap.
- limit[2]=3, requester 2 issues reads continuously with no responses → 3 grants, then blocked. One response to idx 2 → exactly 1 further grant next cycle. busy[2]=1 throughout.
- Same-cycle grant and response to idx 1 with outstanding=5 → stays 5; err_underflow stays 0.
- up_almfull=1 for 4 cycles with requests pending → no grant, ptr unchanged. Deassert → grant resumes from the prior ptr.
- outstanding[3]=7, pulse sub_afu_reset[3] → outstanding 0, no grant to 3 during the pulse. Later rsp_idx=3 → err_underflow=1 and sticky until reset. cfg_limit=0 for idx 3 → its reads are never granted, its writes still are.

Source files
------------

// File: rtl/vai_rd_credit_sched_if.sv
// Tx-side bundle between the per-AFU request streams, the read-credit
// scheduler and the shared upstream channel. The master side presents
// requests, upstream back-pressure and returning read responses; the slave
// side (the scheduler) returns the one-hot grant.
interface vai_rd_credit_sched_if #(
    parameter int NUM_SUB_AFUS = 15,
    parameter int IDX_W        = $clog2(NUM_SUB_AFUS)
);
    logic [NUM_SUB_AFUS-1:0] req_valid;
    logic [NUM_SUB_AFUS-1:0] req_is_rd;
    logic                    up_almfull;
    logic [NUM_SUB_AFUS-1:0] grant;
    logic                    grant_valid;
    logic [IDX_W-1:0]        grant_idx;
    logic                    rsp_valid;
    logic [IDX_W-1:0]        rsp_idx;

    modport master (
        output req_valid, req_is_rd, up_almfull, rsp_valid, rsp_idx,
        input  grant, grant_valid, grant_idx
    );

    modport slave (
        input  req_valid, req_is_rd, up_almfull, rsp_valid, rsp_idx,
        output grant, grant_valid, grant_idx
    );
endinterface

// File: rtl/vai_rd_credit_sched.sv
// Per-sub-AFU read-credit scheduler for the VAI multiplexer Tx path.
// Grants at most one requester per cycle, round-robin from a rotating
// pointer, and caps each tenant's outstanding upstream reads at a
// programmable limit. The manager can reprogram limits and flush a tenant's
// counter; responses to an empty counter raise a sticky underflow flag.
module vai_rd_credit_sched #(
    parameter int NUM_SUB_AFUS  = 15,
    parameter int CNT_W         = 8,
    parameter int DEFAULT_LIMIT = 32,
    parameter int IDX_W         = $clog2(NUM_SUB_AFUS)
) (
    input  logic                    clk,
    input  logic                    reset,
    vai_rd_credit_sched_if.slave    bus,
    input  logic [NUM_SUB_AFUS-1:0] sub_afu_reset,
    input  logic                    cfg_wr,
    input  logic [IDX_W-1:0]        cfg_idx,
    input  logic [CNT_W-1:0]        cfg_limit,
    output logic [NUM_SUB_AFUS-1:0] busy,
    output logic                    err_underflow
);
    typedef logic [CNT_W-1:0] cnt_t;

    logic [IDX_W-1:0]        ptr_q, ptr_d;
    cnt_t                    outstanding_q [NUM_SUB_AFUS];
    cnt_t                    outstanding_d [NUM_SUB_AFUS];
    cnt_t                    limit_q       [NUM_SUB_AFUS];
    cnt_t                    limit_d       [NUM_SUB_AFUS];
    logic [NUM_SUB_AFUS-1:0] busy_q, busy_d;
    logic                    err_q, err_d;

    logic [NUM_SUB_AFUS-1:0] elig;
    logic [NUM_SUB_AFUS-1:0] grant_c;
    logic                    grant_valid_c;
    logic [IDX_W-1:0]        grant_idx_c;
    logic                    rsp_out_of_range;

    assign rsp_out_of_range = (int'(bus.rsp_idx) >= NUM_SUB_AFUS);

    // A requester is eligible unless flushed or a read with no credit left.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_SUB_AFUS; i++) begin
            elig[i] = bus.req_valid[i] & ~sub_afu_reset[i] &
                      (~bus.req_is_rd[i] | (outstanding_q[i] < limit_q[i]));
        end
    end

    // Zero-latency round-robin: first eligible index scanning up from ptr, wrapping at N.
    always_comb begin
        int scan;
        grant_c       = '0;
        grant_valid_c = 1'b0;
        grant_idx_c   = '0;
        scan          = 0;
        if (!reset && !bus.up_almfull) begin
            for (int k = 0; k < NUM_SUB_AFUS; k++) begin
                scan = int'(ptr_q) + k;
                if (scan >= NUM_SUB_AFUS) begin
                    scan = scan - NUM_SUB_AFUS;
                end
                if (!grant_valid_c && elig[scan]) begin
                    grant_valid_c = 1'b1;
                    grant_c[scan] = 1'b1;
                    grant_idx_c   = IDX_W'(scan);
                end
            end
        end
    end

    assign bus.grant       = grant_c;
    assign bus.grant_valid = grant_valid_c;
    assign bus.grant_idx   = grant_idx_c;

    // Pointer moves to one past the winner, wrapping explicitly for non-power-of-2 N.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid_c) begin
            if (int'(grant_idx_c) == NUM_SUB_AFUS - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx_c + IDX_W'(1);
            end
        end
    end

    // Credit counters, limit writes, underflow detection and next-state busy.
    always_comb begin
        logic inc;
        logic dec;
        inc           = 1'b0;
        dec           = 1'b0;
        outstanding_d = outstanding_q;
        limit_d       = limit_q;
        err_d         = err_q;
        busy_d        = '0;
        for (int i = 0; i < NUM_SUB_AFUS; i++) begin
            inc = grant_c[i] & bus.req_is_rd[i];
            dec = bus.rsp_valid && (bus.rsp_idx == IDX_W'(i));
            if (sub_afu_reset[i]) begin
                outstanding_d[i] = '0;
            end else if (inc && !dec) begin
                outstanding_d[i] = outstanding_q[i] + CNT_W'(1);
            end else if (dec && !inc) begin
                if (outstanding_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    outstanding_d[i] = outstanding_q[i] - CNT_W'(1);
                end
            end
            if (cfg_wr && (cfg_idx == IDX_W'(i))) begin
                limit_d[i] = cfg_limit;
            end
            busy_d[i] = (outstanding_d[i] != '0);
        end
        if (bus.rsp_valid && rsp_out_of_range) begin
            err_d = 1'b1;
        end
    end

    // State registers with synchronous reset to the power-on configuration.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < NUM_SUB_AFUS; i++) begin
                outstanding_q[i] <= '0;
                limit_q[i]       <= CNT_W'(DEFAULT_LIMIT);
            end
        end else begin
            ptr_q         <= ptr_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            outstanding_q <= outstanding_d;
            limit_q       <= limit_d;
        end
    end

    assign busy          = busy_q;
    assign err_underflow = err_q;
endmodule

// File: tb/tb_vai_rd_credit_sched.sv
// Directed bench for the read-credit scheduler: a 15-requester instance
// covers credits, flush, back-pressure and the non-power-of-2 wrap, and a
// 4-requester instance covers plain round-robin rotation.
module tb_vai_rd_credit_sched;
    localparam int N   = 15;
    localparam int IW  = 4;
    localparam int N4  = 4;
    localparam int IW4 = 2;

    logic          clk;
    logic          reset;
    logic [N-1:0]  sub_afu_reset;
    logic          cfg_wr;
    logic [IW-1:0] cfg_idx;
    logic [7:0]    cfg_limit;
    logic [N-1:0]  busy;
    logic          err_underflow;

    logic [N4-1:0] busy4;
    logic          err4;

    int checks;
    int errors;

    vai_rd_credit_sched_if #(.NUM_SUB_AFUS(N)) bus ();
    vai_rd_credit_sched_if #(.NUM_SUB_AFUS(N4)) bus4 ();

    vai_rd_credit_sched #(.NUM_SUB_AFUS(N)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .sub_afu_reset (sub_afu_reset),
        .cfg_wr        (cfg_wr),
        .cfg_idx       (cfg_idx),
        .cfg_limit     (cfg_limit),
        .busy          (busy),
        .err_underflow (err_underflow)
    );

    vai_rd_credit_sched #(.NUM_SUB_AFUS(N4)) u_dut4 (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus4),
        .sub_afu_reset (4'b0),
        .cfg_wr        (1'b0),
        .cfg_idx       (2'b0),
        .cfg_limit     (8'd0),
        .busy          (busy4),
        .err_underflow (err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives the 15-requester bus for the coming cycle.
    task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] is_rd,
                                 input logic almfull, input logic rv, input logic [IW-1:0] ridx);
        bus.req_valid  = valid;
        bus.req_is_rd  = is_rd;
        bus.up_almfull = almfull;
        bus.rsp_valid  = rv;
        bus.rsp_idx    = ridx;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expectGrant(input string tag, input logic gv, input int idx);
        @(negedge clk);
        checkOutput({tag, "_gv"}, 32'(bus.grant_valid), 32'(gv));
        if (gv) begin
            checkOutput({tag, "_idx"}, 32'(bus.grant_idx), 32'(idx));
            checkOutput({tag, "_onehot"}, 32'(bus.grant), 32'(1) << idx);
        end else begin
            checkOutput({tag, "_idx0"}, 32'(bus.grant_idx), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] exp_gv3;
        checks = 0;
        errors = 0;

        // Reset with every requester asserting: no grant may escape.
        reset          = 1'b1;
        sub_afu_reset  = '0;
        cfg_wr         = 1'b0;
        cfg_idx        = '0;
        cfg_limit      = '0;
        applyStimulus('1, '0, 1'b0, 1'b0, '0);
        bus4.req_valid  = '1;
        bus4.req_is_rd  = '0;
        bus4.up_almfull = 1'b0;
        bus4.rsp_valid  = 1'b0;
        bus4.rsp_idx    = '0;
        @(negedge clk);
        checkOutput("rst_gv", 32'(bus.grant_valid), 32'd0);
        checkOutput("rst_gv4", 32'(bus4.grant_valid), 32'd0);
        stepCycle();
        stepCycle();
        applyStimulus('0, '0, 1'b0, 1'b0, '0);
        bus4.req_valid = '0;
        reset          = 1'b0;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(err_underflow), 32'd0);

        // N=4 rotation with all requesters writing.
        bus4.req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkOutput($sformatf("rr4_idx%0d", c), 32'(bus4.grant_idx), 32'(c % 4));
            checkOutput($sformatf("rr4_g%0d", c), 32'(bus4.grant), 32'(1) << (c % 4));
            stepCycle();
        end
        bus4.req_valid = '0;

        // Move ptr to 14, then alternate 14 and 0 across the N=15 wrap.
        applyStimulus(15'(1) << 13, '0, 1'b0, 1'b0, '0);
        expectGrant("wrap_pre", 1'b1, 13);
        stepCycle();
        applyStimulus((15'(1) << 14) | 15'(1), '0, 1'b0, 1'b0, '0);
        for (int c = 0; c < 4; c++) begin
            expectGrant($sformatf("wrap%0d", c), 1'b1, (c % 2 == 0) ? 14 : 0);
            stepCycle();
        end

        // Limit 3 on requester 2: three grants, block, one response frees one slot.
        applyStimulus('0, '0, 1'b0, 1'b0, '0);
        cfg_wr    = 1'b1;
        cfg_idx   = 4'd2;
        cfg_limit = 8'd3;
        stepCycle();
        cfg_wr  = 1'b0;
        exp_gv3 = 8'b0100_0111;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(15'h0004, 15'h0004, 1'b0, (c == 5), 4'd2);
            expectGrant($sformatf("lim%0d", c), exp_gv3[c], 2);
            stepCycle();
            checkOutput($sformatf("lim_busy%0d", c), 32'(busy[2]), 32'd1);
        end
        for (int c = 0; c < 3; c++) begin
            applyStimulus('0, '0, 1'b0, 1'b1, 4'd2);
            stepCycle();
        end
        applyStimulus('0, '0, 1'b0, 1'b0, '0);
        checkOutput("lim_drain_busy", 32'(busy[2]), 32'd0);
        checkOutput("lim_drain_err", 32'(err_underflow), 32'd0);

        // Requester 1 at 5 outstanding, then grant and response in the same cycle.
        for (int c = 0; c < 5; c++) begin
            applyStimulus(15'h0002, 15'h0002, 1'b0, 1'b0, '0);
            expectGrant($sformatf("same_fill%0d", c), 1'b1, 1);
            stepCycle();
        end
        applyStimulus(15'h0002, 15'h0002, 1'b0, 1'b1, 4'd1);
        expectGrant("same_cycle", 1'b1, 1);
        stepCycle();
        for (int c = 0; c < 5; c++) begin
            applyStimulus('0, '0, 1'b0, 1'b1, 4'd1);
            stepCycle();
            if (c == 3) checkOutput("same_busy4", 32'(busy[1]), 32'd1);
        end
        applyStimulus('0, '0, 1'b0, 1'b0, '0);
        checkOutput("same_busy5", 32'(busy[1]), 32'd0);
        checkOutput("same_err", 32'(err_underflow), 32'd0);

        // Back-pressure holds the pointer at 2; release grants 3 then 0.
        for (int c = 0; c < 4; c++) begin
            applyStimulus(15'h0009, '0, 1'b1, 1'b0, '0);
            expectGrant($sformatf("almf%0d", c), 1'b0, 0);
            stepCycle();
        end
        applyStimulus(15'h0009, '0, 1'b0, 1'b0, '0);
        expectGrant("almf_rel0", 1'b1, 3);
        stepCycle();
        expectGrant("almf_rel1", 1'b1, 0);
        stepCycle();

        // Requester 3 to 7 outstanding, flush it, then a late response.
        for (int c = 0; c < 7; c++) begin
            applyStimulus(15'h0008, 15'h0008, 1'b0, 1'b0, '0);
            expectGrant($sformatf("fl_fill%0d", c), 1'b1, 3);
            stepCycle();
        end
        sub_afu_reset = 15'h0008;
        applyStimulus(15'h0008, 15'h0008, 1'b0, 1'b1, 4'd3);
        expectGrant("fl_pulse", 1'b0, 0);
        stepCycle();
        sub_afu_reset = '0;
        applyStimulus('0, '0, 1'b0, 1'b0, '0);
        checkOutput("fl_busy", 32'(busy[3]), 32'd0);
        checkOutput("fl_err", 32'(err_underflow), 32'd0);
        applyStimulus('0, '0, 1'b0, 1'b1, 4'd3);
        stepCycle();
        applyStimulus('0, '0, 1'b0, 1'b0, '0);
        checkOutput("late_err", 32'(err_underflow), 32'd1);
        stepCycle();
        checkOutput("late_err_sticky", 32'(err_underflow), 32'd1);
        cfg_wr    = 1'b1;
        cfg_idx   = 4'd3;
        cfg_limit = 8'd0;
        stepCycle();
        cfg_wr = 1'b0;
        for (int c = 0; c < 2; c++) begin
            applyStimulus(15'h0008, 15'h0008, 1'b0, 1'b0, '0);
            expectGrant($sformatf("lim0_rd%0d", c), 1'b0, 0);
            stepCycle();
        end
        applyStimulus(15'h0008, '0, 1'b0, 1'b0, '0);
        expectGrant("lim0_wr", 1'b1, 3);
        stepCycle();
        checkOutput("lim0_busy", 32'(busy[3]), 32'd0);

        // Reset mid-operation clears counters and pointer; later responses underflow.
        for (int c = 0; c < 2; c++) begin
            applyStimulus(15'h0020, 15'h0020, 1'b0, 1'b0, '0);
            expectGrant($sformatf("mid_fill%0d", c), 1'b1, 5);
            stepCycle();
        end
        checkOutput("mid_busy_pre", 32'(busy[5]), 32'd1);
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        checkOutput("mid_busy", 32'(busy), 32'd0);
        checkOutput("mid_err", 32'(err_underflow), 32'd0);
        applyStimulus(15'h00A0, '0, 1'b0, 1'b0, '0);
        expectGrant("mid_ptr0", 1'b1, 5);
        stepCycle();
        applyStimulus('0, '0, 1'b0, 1'b1, 4'd5);
        stepCycle();
        applyStimulus('0, '0, 1'b0, 1'b0, '0);
        checkOutput("mid_late_err", 32'(err_underflow), 32'd1);

        // Out-of-range response index raises underflow from a clean state.
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        checkOutput("oor_err_pre", 32'(err_underflow), 32'd0);
        applyStimulus('0, '0, 1'b0, 1'b1, 4'd15);
        stepCycle();
        applyStimulus('0, '0, 1'b0, 1'b0, '0);
        checkOutput("oor_err", 32'(err_underflow), 32'd1);
        stepCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
